// File: rtl/pipe_hilo_mdu_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hilo_mdu_if
// Description : Bundles the EX-stage issue bus, the WB-stage HI/LO read
//               selects and the MDU status/read-back signals. These are the
//               signals exchanged between the pipeline and pipe_hilo_mdu.
//   Signals   : estart  - issue strobe from EX (one cycle per instruction)
//               eop     - operation code (mult/multu/div/divu/mthi/mtlo)
//               ea, eb  - rs / rt operands
//               wmfhi   - WB-stage mfhi select
//               wmflo   - WB-stage mflo select
//               hilo_rd - HI/LO read data to the writeback mux
//               busy    - engine running (hazard unit stalls on it)
//               done    - one-cycle pulse when HI/LO take a mult/div result
//   Modports  : master - pipeline side; slave - MDU side
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_hilo_mdu_if #(
  parameter int WIDTH = 32
);
  logic             estart;
  logic [2:0]       eop;
  logic [WIDTH-1:0] ea;
  logic [WIDTH-1:0] eb;
  logic             wmfhi;
  logic             wmflo;
  logic [WIDTH-1:0] hilo_rd;
  logic             busy;
  logic             done;

  modport master (
    output estart, eop, ea, eb, wmfhi, wmflo,
    input  hilo_rd, busy, done
  );

  modport slave (
    input  estart, eop, ea, eb, wmfhi, wmflo,
    output hilo_rd, busy, done
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : pipe_hilo_mdu
// Description : HI/LO register unit with an iterative multiply/divide engine
//               for the pipelined MIPS CPU. Multiplication is shift-add and
//               division is restoring, both on operand magnitudes and one
//               bit per cycle; the sign is applied in a final FIX cycle.
//   Ports     : clk  - clock, all state changes on the rising edge
//               clrn - asynchronous, active-high reset
//               bus  - pipe_hilo_mdu_if.slave (issue, read selects,
//                      hilo_rd / busy / done)
//   Option    : define HILO_BYPASS_EN to forward the value being written to
//               HI/LO on the current edge straight to hilo_rd.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_hilo_mdu #(
  parameter int WIDTH = 32
) (
  input  wire logic       clk,
  input  wire logic       clrn,
  pipe_hilo_mdu_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_t             state_q,  state_d;
  logic [CNT_W-1:0]   count_q,  count_d;
  logic [WIDTH-1:0]   hi_q,     hi_d;
  logic [WIDTH-1:0]   lo_q,     lo_d;
  // MUL: {partial product high, multiplier shifting out / product low}
  // DIV: {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] acc_q,    acc_d;
  // MUL: |multiplicand|   DIV: |divisor|
  logic [WIDTH-1:0]   opb_q,    opb_d;
  logic               is_div_q, is_div_d;
  logic               sq_q,     sq_d;
  logic               sr_q,     sr_d;
  logic               dz_q,     dz_d;
  logic [WIDTH-1:0]   araw_q,   araw_d;

  // --------------------------------------------------------------------------
  // Issue decode and operand magnitudes
  // --------------------------------------------------------------------------
  logic             w_issue;
  logic             w_op_mul;
  logic             w_op_div;
  logic             w_op_signed;
  logic             w_sa;
  logic             w_sb;
  logic [WIDTH-1:0] w_amag;
  logic [WIDTH-1:0] w_bmag;

  assign w_issue     = (state_q == ST_IDLE) && bus.estart;
  assign w_op_mul    = (bus.eop == OP_MULT) || (bus.eop == OP_MULTU);
  assign w_op_div    = (bus.eop == OP_DIV)  || (bus.eop == OP_DIVU);
  assign w_op_signed = (bus.eop == OP_MULT) || (bus.eop == OP_DIV);
  assign w_sa        = w_op_signed && bus.ea[WIDTH-1];
  assign w_sb        = w_op_signed && bus.eb[WIDTH-1];
  assign w_amag      = w_sa ? (~bus.ea + 1'b1) : bus.ea;
  assign w_bmag      = w_sb ? (~bus.eb + 1'b1) : bus.eb;

  // --------------------------------------------------------------------------
  // Iteration datapaths
  // --------------------------------------------------------------------------
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_trial;
  logic [WIDTH:0]   w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_rem_next;

  // Add the multiplicand when the current multiplier bit is set; the carry
  // out lands in the top bit after the right shift.
  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

  // Shift the next dividend bit into the partial remainder and try the
  // subtraction; the remainder is always below the divisor so it fits WIDTH.
  assign w_trial    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_diff     = w_trial - {1'b0, opb_q};
  assign w_ge       = (w_trial >= {1'b0, opb_q});
  assign w_rem_next = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Sign fix-up of the finished result
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [WIDTH-1:0]   w_fix_lo;

  assign w_prod = sq_q ? (~acc_q + 1'b1) : acc_q;
  assign w_quo  = sq_q ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign w_rem  = sr_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                       : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    w_fix_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fix_lo = w_prod[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        // Divide by zero: quotient saturates, remainder is the raw dividend.
        w_fix_hi = araw_q;
        w_fix_lo = {WIDTH{1'b1}};
      end else begin
        w_fix_hi = w_rem;
        w_fix_lo = w_quo;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    acc_d    = acc_q;
    opb_d    = opb_q;
    is_div_d = is_div_q;
    sq_d     = sq_q;
    sr_d     = sr_q;
    dz_d     = dz_q;
    araw_d   = araw_q;

    case (state_q)
      ST_IDLE: begin
        if (w_issue) begin
          if (bus.eop == OP_MTHI) begin
            hi_d = bus.ea;
          end else if (bus.eop == OP_MTLO) begin
            lo_d = bus.ea;
          end else if (w_op_mul || w_op_div) begin
            count_d  = '0;
            is_div_d = w_op_div;
            sq_d     = w_sa ^ w_sb;
            sr_d     = w_sa;
            dz_d     = w_op_div && (bus.eb == '0);
            araw_d   = bus.ea;
            if (w_op_mul) begin
              acc_d   = {{WIDTH{1'b0}}, w_bmag};
              opb_d   = w_amag;
              state_d = ST_MUL;
            end else begin
              acc_d   = {{WIDTH{1'b0}}, w_amag};
              opb_d   = w_bmag;
              state_d = ST_DIV;
            end
          end
        end
      end

      ST_MUL: begin
        acc_d   = {w_mul_sum, acc_q[WIDTH-1:1]};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_DIV: begin
        acc_d   = {w_rem_next, acc_q[WIDTH-2:0], w_ge};
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end

      ST_FIX: begin
        hi_d    = w_fix_hi;
        lo_d    = w_fix_lo;
        count_d = '0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge clrn) begin
    if (clrn) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      acc_q    <= '0;
      opb_q    <= '0;
      is_div_q <= 1'b0;
      sq_q     <= 1'b0;
      sr_q     <= 1'b0;
      dz_q     <= 1'b0;
      araw_q   <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      acc_q    <= acc_d;
      opb_q    <= opb_d;
      is_div_q <= is_div_d;
      sq_q     <= sq_d;
      sr_q     <= sr_d;
      dz_q     <= dz_d;
      araw_q   <= araw_d;
    end
  end

  // --------------------------------------------------------------------------
  // Status and read-back
  // --------------------------------------------------------------------------
  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = (state_q == ST_FIX);

  logic [WIDTH-1:0] w_hi_view;
  logic [WIDTH-1:0] w_lo_view;

`ifdef HILO_BYPASS_EN
  // Forward whatever HI/LO will take on the coming edge.
  logic w_wr_mthi;
  logic w_wr_mtlo;
  assign w_wr_mthi = w_issue && (bus.eop == OP_MTHI);
  assign w_wr_mtlo = w_issue && (bus.eop == OP_MTLO);
  assign w_hi_view = w_wr_mthi ? bus.ea
                   : (state_q == ST_FIX) ? w_fix_hi : hi_q;
  assign w_lo_view = w_wr_mtlo ? bus.ea
                   : (state_q == ST_FIX) ? w_fix_lo : lo_q;
`else
  assign w_hi_view = hi_q;
  assign w_lo_view = lo_q;
`endif

  // mfhi wins when both selects are set.
  assign bus.hilo_rd = bus.wmfhi ? w_hi_view
                     : bus.wmflo ? w_lo_view
                     : {WIDTH{1'b0}};

endmodule
`default_nettype wire

// File: tb/tb_pipe_hilo_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_hilo_mdu
// Description : Scoreboard bench for pipe_hilo_mdu. Stimulus pushes the
//               expected HI/LO pair of each operation; a monitor pops it on
//               every done pulse (or on a read request) and reads HI/LO back
//               through wmfhi/wmflo.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_hilo_mdu;

  localparam int W = 32;

  logic clk;
  logic clrn;

  pipe_hilo_mdu_if #(.WIDTH(W)) bus ();

  pipe_hilo_mdu #(.WIDTH(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic        is_done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [7:0]  id;
  } exp_t;

  exp_t exp_q[$];
  int   rd_pend    = 0;
  bit   mon_active = 0;
  int   busy_run   = 0;
  int   n_chk      = 0;
  int   n_pass     = 0;
  int   item_id    = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic expect_done(input logic [31:0] hi, input logic [31:0] lo);
    exp_q.push_back({1'b1, hi, lo, 8'(item_id)});
    item_id++;
  endtask

  task automatic expect_read(input logic [31:0] hi, input logic [31:0] lo);
    exp_q.push_back({1'b0, hi, lo, 8'(item_id)});
    item_id++;
    rd_pend++;
  endtask

  // Caller is at posedge+1; drives one issue cycle and returns at posedge+1.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.estart = 1'b1; bus.eop = op; bus.ea = a; bus.eb = b;
    @(posedge clk); #1;
    bus.estart = 1'b0; bus.eop = 3'b111;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      if (exp_q.size() == 0 && rd_pend == 0 && !mon_active) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_chk++;
      $display("FAIL drain_timeout: got %0d pending items expected 0", exp_q.size());
      exp_q.delete();
      rd_pend = 0;
    end
    #1;
  endtask

  task automatic do_reads(input int id, input logic [31:0] ehi, input logic [31:0] elo);
    bus.wmfhi = 1'b1; bus.wmflo = 1'b0; #1;
    chk($sformatf("mfhi[%0d]", id), bus.hilo_rd, ehi);
    bus.wmfhi = 1'b0; bus.wmflo = 1'b1; #1;
    chk($sformatf("mflo[%0d]", id), bus.hilo_rd, elo);
    bus.wmfhi = 1'b1; bus.wmflo = 1'b1; #1;
    chk($sformatf("both_sel[%0d]", id), bus.hilo_rd, ehi);
    bus.wmfhi = 1'b0; bus.wmflo = 1'b0; #1;
    chk($sformatf("no_sel[%0d]", id), bus.hilo_rd, 32'h0);
  endtask

  // Monitor: consumes scoreboard entries on done pulses and read requests.
  initial begin : monitor
    exp_t e;
    bit   by_done;
    forever begin
      @(negedge clk);
      if (bus.busy === 1'b1) busy_run++;
      else busy_run = 0;
      if (bus.done === 1'b1 || rd_pend > 0) begin
        mon_active = 1'b1;
        by_done = (bus.done === 1'b1);
        if (!by_done) rd_pend--;
        if (exp_q.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_event: got done=%b with empty scoreboard expected no event", bus.done);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("done_pulse[%0d]", e.id), 32'(by_done), 32'(e.is_done));
          if (by_done) begin
            chk($sformatf("busy_cycles[%0d]", e.id), busy_run, 33);
            @(posedge clk); #1;
            chk($sformatf("done_low[%0d]", e.id), 32'(bus.done), 32'h0);
            chk($sformatf("busy_low[%0d]", e.id), 32'(bus.busy), 32'h0);
          end else begin
            chk($sformatf("busy_idle[%0d]", e.id), busy_run, 0);
          end
          do_reads(e.id, e.hi, e.lo);
        end
        mon_active = 1'b0;
      end
    end
  end

  initial begin : stimulus
    clrn = 1'b0;
    bus.estart = 1'b0; bus.eop = 3'b111; bus.ea = '0; bus.eb = '0;
    bus.wmfhi = 1'b0; bus.wmflo = 1'b0;
    #1 clrn = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset_busy", 32'(bus.busy), 32'h0);
    chk("reset_done", 32'(bus.done), 32'h0);
    clrn = 1'b0;
    expect_read(32'h0, 32'h0);
    wait_idle();

    // mthi then mtlo on consecutive cycles
    bus.estart = 1'b1; bus.eop = 3'b100; bus.ea = 32'h12345678;
    @(posedge clk); #1;
    bus.eop = 3'b101; bus.ea = 32'h9ABCDEF0;
    @(posedge clk); #1;
    bus.estart = 1'b0; bus.eop = 3'b111;
    expect_read(32'h12345678, 32'h9ABCDEF0);
    wait_idle();

    // signed mult -3 * 7 = -21
    expect_done(32'hFFFFFFFF, 32'hFFFFFFEB);
    issue(3'b000, 32'hFFFFFFFD, 32'd7);
    wait_idle();

    // signed div -7 / 2 -> q=-3, r=-1
    expect_done(32'hFFFFFFFF, 32'hFFFFFFFD);
    issue(3'b010, 32'hFFFFFFF9, 32'd2);
    wait_idle();

    // divu by zero
    expect_done(32'd100, 32'hFFFFFFFF);
    issue(3'b011, 32'd100, 32'd0);
    wait_idle();

    // signed div by zero keeps raw dividend in HI
    expect_done(32'hFFFFFFF9, 32'hFFFFFFFF);
    issue(3'b010, 32'hFFFFFFF9, 32'd0);
    wait_idle();

    // signed overflow
    expect_done(32'h0, 32'h80000000);
    issue(3'b010, 32'h80000000, 32'hFFFFFFFF);
    wait_idle();

    // most-negative squared
    expect_done(32'h40000000, 32'h00000000);
    issue(3'b000, 32'h80000000, 32'h80000000);
    wait_idle();

    // negative * negative
    expect_done(32'h0, 32'h1E);
    issue(3'b000, 32'hFFFFFFFB, 32'hFFFFFFFA);
    wait_idle();

    // no-op codes leave HI/LO untouched
    issue(3'b110, 32'hCAFEF00D, 32'h1);
    issue(3'b111, 32'hCAFEF00D, 32'h1);
    expect_read(32'h0, 32'h1E);
    wait_idle();

    // reset in the middle of a multu
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (9) @(posedge clk);
    #2 clrn = 1'b1;
    #1;
    chk("midop_busy", 32'(bus.busy), 32'h0);
    chk("midop_done", 32'(bus.done), 32'h0);
    @(posedge clk); #1 clrn = 1'b0;
    expect_read(32'h0, 32'h0);
    wait_idle();

    // re-issued multu
    expect_done(32'hFFFFFFFE, 32'h00000001);
    issue(3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_idle();

    // mthi during a div is ignored: 100 / 7 -> q=14, r=2
    expect_done(32'd2, 32'd14);
    issue(3'b010, 32'd100, 32'd7);
    repeat (5) @(posedge clk);
    #1;
    issue(3'b100, 32'hDEADBEEF, 32'h0);
    wait_idle();

    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL leftover: got %0d items expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
